// File: rtl/rv_core_pkg.sv
// Shared core types: architectural widths and the writeback entry carried
// from execution units to the register file write port.
package rv_core_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int POS_W      = 4;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
    logic [POS_W-1:0]      pos;
  } wb_entry_t;
endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: ALU and long-latency result inputs, issue/scoreboard
// query, and the register file write port.
interface wb_arbiter_if;
  import rv_core_pkg::*;

  logic                  alu_valid_i;
  logic [REG_ADDR_W-1:0] alu_rd_i;
  logic [XLEN-1:0]       alu_data_i;
  logic [POS_W-1:0]      alu_pos_i;

  logic                  ll_valid_i;
  logic                  ll_ready_o;
  logic [REG_ADDR_W-1:0] ll_rd_i;
  logic [XLEN-1:0]       ll_data_i;
  logic [POS_W-1:0]      ll_pos_i;

  logic                  issue_ll_i;
  logic [REG_ADDR_W-1:0] issue_rd_i;
  logic [REG_ADDR_W-1:0] rs_addr_i;
  logic [REG_ADDR_W-1:0] rt_addr_i;
  logic [REG_ADDR_W-1:0] rd_addr_i;
  logic                  busy_o;

  logic [REG_ADDR_W-1:0] RDaddr_o;
  logic [XLEN-1:0]       RDdata_o;
  logic                  RegWrite_o;
  logic [POS_W-1:0]      is_pos_o;

  // Arbiter side.
  modport slave (
    input  alu_valid_i, alu_rd_i, alu_data_i, alu_pos_i,
    input  ll_valid_i, ll_rd_i, ll_data_i, ll_pos_i,
    input  issue_ll_i, issue_rd_i, rs_addr_i, rt_addr_i, rd_addr_i,
    output ll_ready_o, busy_o, RDaddr_o, RDdata_o, RegWrite_o, is_pos_o
  );

  // Pipeline / register file side.
  modport master (
    output alu_valid_i, alu_rd_i, alu_data_i, alu_pos_i,
    output ll_valid_i, ll_rd_i, ll_data_i, ll_pos_i,
    output issue_ll_i, issue_rd_i, rs_addr_i, rt_addr_i, rd_addr_i,
    input  ll_ready_o, busy_o, RDaddr_o, RDdata_o, RegWrite_o, is_pos_o
  );
endinterface

// File: rtl/wb_fifo.sv
// Small FIFO of writeback entries for long-latency results; no bypass,
// head is valid whenever empty_o is low.
module wb_fifo
  import rv_core_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk_i,
  input  logic      reset,
  input  logic      push_i,
  input  wb_entry_t data_i,
  input  logic      pop_i,
  output logic      full_o,
  output logic      empty_o,
  output wb_entry_t head_o
);
  localparam int AW = $clog2(DEPTH);

  wb_entry_t     mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    cnt_d = cnt_q;
    if (do_push) cnt_d = cnt_d + (AW+1)'(1);
    if (do_pop)  cnt_d = cnt_d - (AW+1)'(1);
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU results take priority over buffered long-latency
// results; a pending scoreboard tracks outstanding long-latency writes.
module wb_arbiter
  import rv_core_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic         clk_i,
  input  logic         reset,
  wb_arbiter_if.slave  bus
);
  logic      fifo_full, fifo_empty, fifo_push, fifo_pop;
  wb_entry_t fifo_head, ll_entry;

  logic [31:0]           pending_q, pending_d;
  logic [REG_ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [XLEN-1:0]       rd_data_q, rd_data_d;
  logic [POS_W-1:0]      pos_q, pos_d;
  logic                  we_q, we_d;

  assign ll_entry  = '{rd: bus.ll_rd_i, data: bus.ll_data_i, pos: bus.ll_pos_i};
  assign fifo_push = bus.ll_valid_i & bus.ll_ready_o;
  assign fifo_pop  = ~bus.alu_valid_i & ~fifo_empty;

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .reset   (reset),
    .push_i  (fifo_push),
    .data_i  (ll_entry),
    .pop_i   (fifo_pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  assign bus.ll_ready_o = ~fifo_full & ~reset;
  assign bus.busy_o     = pending_q[bus.rs_addr_i] | pending_q[bus.rt_addr_i]
                        | pending_q[bus.rd_addr_i];

  assign bus.RDaddr_o   = rd_addr_q;
  assign bus.RDdata_o   = rd_data_q;
  assign bus.RegWrite_o = we_q;
  assign bus.is_pos_o   = pos_q;

  always_comb begin
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    pos_d     = pos_q;
    we_d      = 1'b0;
    if (bus.alu_valid_i) begin
      rd_addr_d = bus.alu_rd_i;
      rd_data_d = bus.alu_data_i;
      pos_d     = bus.alu_pos_i;
      we_d      = (bus.alu_rd_i != '0);
    end else if (fifo_pop) begin
      rd_addr_d = fifo_head.rd;
      rd_data_d = fifo_head.data;
      pos_d     = fifo_head.pos;
      we_d      = (fifo_head.rd != '0);
    end
  end

  // Clear before set so a same-edge re-issue of the popped register wins.
  always_comb begin
    pending_d = pending_q;
    if (fifo_pop)                               pending_d[fifo_head.rd] = 1'b0;
    if (bus.issue_ll_i && bus.issue_rd_i != '0) pending_d[bus.issue_rd_i] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
      pos_q     <= '0;
      we_q      <= 1'b0;
    end else begin
      pending_q <= pending_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
      pos_q     <= pos_d;
      we_q      <= we_d;
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a reference FIFO/pending model predicts
// each output-stage load; predictions queue up and are compared after the edge.
module tb_wb_arbiter;
  import rv_core_pkg::*;

  localparam int DEPTH = 2;

  typedef struct packed {
    logic                  we;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
    logic [POS_W-1:0]      pos;
  } exp_t;

  logic clk, rst;
  wb_arbiter_if bus();

  wb_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_i (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int        nvec, nerr;
  exp_t      expq[$];
  wb_entry_t mq[$];
  logic [31:0] mpend;
  exp_t      m_out;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    bus.alu_valid_i = 0; bus.alu_rd_i = 0; bus.alu_data_i = 0; bus.alu_pos_i = 0;
    bus.ll_valid_i  = 0; bus.ll_rd_i  = 0; bus.ll_data_i  = 0; bus.ll_pos_i  = 0;
    bus.issue_ll_i  = 0; bus.issue_rd_i = 0;
    bus.rs_addr_i   = 0; bus.rt_addr_i  = 0; bus.rd_addr_i = 0;
  endtask

  task automatic alu(input logic v, input logic [4:0] rd, input logic [31:0] d, input logic [3:0] p);
    bus.alu_valid_i = v; bus.alu_rd_i = rd; bus.alu_data_i = d; bus.alu_pos_i = p;
  endtask

  task automatic ll(input logic v, input logic [4:0] rd, input logic [31:0] d, input logic [3:0] p);
    bus.ll_valid_i = v; bus.ll_rd_i = rd; bus.ll_data_i = d; bus.ll_pos_i = p;
  endtask

  task automatic issue(input logic v, input logic [4:0] rd);
    bus.issue_ll_i = v; bus.issue_rd_i = rd;
  endtask

  // Inputs are set just after a posedge; predict, clock, then compare.
  task automatic tick();
    exp_t      e;
    wb_entry_t h;
    logic      rdy, bz;
    #1;
    rdy = (mq.size() < DEPTH) && !rst;
    chk("ll_ready", {31'd0, bus.ll_ready_o}, {31'd0, rdy});
    bz = mpend[bus.rs_addr_i] | mpend[bus.rt_addr_i] | mpend[bus.rd_addr_i];
    chk("busy", {31'd0, bus.busy_o}, {31'd0, bz});
    e = m_out;
    e.we = 1'b0;
    if (bus.alu_valid_i) begin
      e = '{we: bus.alu_rd_i != 0, rd: bus.alu_rd_i, data: bus.alu_data_i, pos: bus.alu_pos_i};
    end else if (mq.size() > 0) begin
      h = mq.pop_front();
      e = '{we: h.rd != 0, rd: h.rd, data: h.data, pos: h.pos};
      mpend[h.rd] = 1'b0;
    end
    if (bus.ll_valid_i && rdy)
      mq.push_back('{rd: bus.ll_rd_i, data: bus.ll_data_i, pos: bus.ll_pos_i});
    if (bus.issue_ll_i && bus.issue_rd_i != 0) mpend[bus.issue_rd_i] = 1'b1;
    m_out = e;
    expq.push_back(e);
    @(posedge clk);
    #1;
    e = expq.pop_front();
    chk("RegWrite", {31'd0, bus.RegWrite_o}, {31'd0, e.we});
    chk("RDaddr",   {27'd0, bus.RDaddr_o},   {27'd0, e.rd});
    chk("RDdata",   bus.RDdata_o,            e.data);
    chk("is_pos",   {28'd0, bus.is_pos_o},   {28'd0, e.pos});
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_we"},    {31'd0, bus.RegWrite_o}, 32'd0);
    chk({tag, "_addr"},  {27'd0, bus.RDaddr_o},   32'd0);
    chk({tag, "_data"},  bus.RDdata_o,            32'd0);
    chk({tag, "_pos"},   {28'd0, bus.is_pos_o},   32'd0);
    chk({tag, "_ready"}, {31'd0, bus.ll_ready_o}, 32'd0);
    chk({tag, "_busy"},  {31'd0, bus.busy_o},     32'd0);
  endtask

  task automatic model_reset();
    mq.delete();
    expq.delete();
    mpend = '0;
    m_out = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    nvec = 0; nerr = 0;
    model_reset();
    idle();
    rst = 1'b1;
    #12;
    chk_reset_state("por");
    @(posedge clk); #1;
    rst = 1'b0;
    tick();

    // ALU only
    alu(1, 5, 32'hDEADBEEF, 3);
    tick();
    idle();
    tick();

    // Arbitration: LL entry waits behind three ALU writes
    issue(1, 7);
    tick();
    issue(0, 0);
    bus.rd_addr_i = 7;
    alu(1, 1, 32'h100, 1);
    ll(1, 7, 32'h11, 2);
    tick();
    ll(0, 0, 0, 0);
    alu(1, 2, 32'h200, 1);
    tick();
    alu(1, 3, 32'h300, 1);
    tick();
    alu(0, 0, 0, 0);
    tick();
    tick();

    // FIFO full with ALU hogging the port
    alu(1, 10, 32'hA0, 4);
    ll(1, 3, 32'hA1, 1);
    tick();
    ll(1, 4, 32'hA2, 2);
    tick();
    ll(1, 6, 32'hA3, 3);
    tick();
    tick();
    alu(0, 0, 0, 0);
    tick();
    alu(1, 11, 32'hB0, 5);
    tick();
    ll(0, 0, 0, 0);
    alu(0, 0, 0, 0);
    tick();
    tick();
    tick();

    // Reset mid-stream with a full FIFO and pending = 0x30
    issue(1, 4);
    tick();
    issue(1, 5);
    tick();
    issue(0, 0);
    alu(1, 12, 32'hC0, 6);
    ll(1, 4, 32'hD4, 7);
    tick();
    ll(1, 5, 32'hD5, 8);
    tick();
    ll(0, 0, 0, 0);
    bus.rs_addr_i = 4; bus.rt_addr_i = 5;
    #1;
    chk("pre_reset_busy", {31'd0, bus.busy_o}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    model_reset();
    chk_reset_state("midrst");
    @(posedge clk); #1;
    chk_reset_state("midrst_hold");
    rst = 1'b0;
    alu(0, 0, 0, 0);
    tick();
    tick();

    // x0 destination consumes a slot without writing
    bus.rs_addr_i = 0; bus.rt_addr_i = 0;
    ll(1, 0, 32'h55, 5);
    tick();
    ll(0, 0, 0, 0);
    tick();
    tick();

    // Same-edge set and clear on r9: set wins
    issue(1, 9);
    bus.rd_addr_i = 9;
    tick();
    issue(0, 0);
    ll(1, 9, 32'h99, 6);
    tick();
    ll(0, 0, 0, 0);
    issue(1, 9);
    tick();
    issue(0, 0);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
